// File: rtl/dma_rf_pkg.sv
// Shared constants for the DMA channel register file.
// Register offsets, global-region base and 2-bit mode/width encodings.
package dma_rf_pkg;

    localparam logic [2:0] REG_SRC      = 3'd0;
    localparam logic [2:0] REG_DST      = 3'd1;
    localparam logic [2:0] REG_SRC_TYPE = 3'd2;
    localparam logic [2:0] REG_DST_TYPE = 3'd3;
    localparam logic [2:0] REG_SRC_W    = 3'd4;
    localparam logic [2:0] REG_DST_W    = 3'd5;
    localparam logic [2:0] REG_TOTAL    = 3'd6;
    localparam logic [2:0] REG_CTRL     = 3'd7;

    localparam int CTRL_SW_START = 0;
    localparam int CTRL_HW_EN    = 1;

    localparam logic [8:0] GLB_BASE = 9'h100;

    localparam logic [1:0] GLB_INT_STATUS = 2'd0;
    localparam logic [1:0] GLB_INT_MASK   = 2'd1;
    localparam logic [1:0] GLB_BUSY       = 2'd2;

    typedef enum logic [1:0] {
        ADDR_INCR  = 2'd0,
        ADDR_DECR  = 2'd1,
        ADDR_FIXED = 2'd2,
        ADDR_RSVD  = 2'd3
    } addr_type_e;

    typedef enum logic [1:0] {
        WIDTH_8  = 2'd0,
        WIDTH_16 = 2'd1,
        WIDTH_32 = 2'd2,
        WIDTH_64 = 2'd3
    } data_width_e;

endpackage

// File: rtl/dma_rf_channel.sv
// One DMA channel: config registers, busy flag and start pulse.
// Error output exists only when DMA_RF_ERR_EN is defined.
module dma_rf_channel
    import dma_rf_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [2:0]            i_reg,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_hw_trig,
    input  logic                  i_ch_done,
    output logic                  o_start,
    output logic                  o_busy,
    output logic [DATA_WIDTH-1:0] o_src_addr,
    output logic [DATA_WIDTH-1:0] o_dst_addr,
    output logic [DATA_WIDTH-1:0] o_total,
    output logic [1:0]            o_src_type,
    output logic [1:0]            o_dst_type,
    output logic [1:0]            o_src_width,
    output logic [1:0]            o_dst_width,
    output logic [DATA_WIDTH-1:0] o_rd_word
`ifdef DMA_RF_ERR_EN
    ,
    output logic                  o_err
`endif
);

    logic [DATA_WIDTH-1:0] r_src;
    logic [DATA_WIDTH-1:0] r_dst;
    logic [DATA_WIDTH-1:0] r_total;
    addr_type_e            r_src_type;
    addr_type_e            r_dst_type;
    data_width_e           r_src_w;
    data_width_e           r_dst_w;
    logic                  r_hw_en;
    logic                  r_busy;
    logic                  r_start;

    logic w_cfg_wr;
    logic w_ctrl_wr;
    logic w_start_req;
    logic w_launch;

    assign w_cfg_wr    = i_wr_en & ~r_busy & (i_reg != REG_CTRL);
    assign w_ctrl_wr   = i_wr_en & (i_reg == REG_CTRL);
    assign w_start_req = (w_ctrl_wr & i_data[CTRL_SW_START])
                       | (r_hw_en & i_hw_trig);
    assign w_launch    = w_start_req & ~r_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_total    <= '0;
            r_src_type <= ADDR_INCR;
            r_dst_type <= ADDR_INCR;
            r_src_w    <= WIDTH_8;
            r_dst_w    <= WIDTH_8;
            r_hw_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
        end else begin
            r_start <= w_launch;
            // A launch only happens when idle, so it never races a done.
            if (w_launch)
                r_busy <= 1'b1;
            else if (i_ch_done)
                r_busy <= 1'b0;
            if (w_ctrl_wr)
                r_hw_en <= i_data[CTRL_HW_EN];
            if (w_cfg_wr) begin
                case (i_reg)
                    REG_SRC:      r_src      <= i_data;
                    REG_DST:      r_dst      <= i_data;
                    REG_SRC_TYPE: r_src_type <= addr_type_e'(i_data[1:0]);
                    REG_DST_TYPE: r_dst_type <= addr_type_e'(i_data[1:0]);
                    REG_SRC_W:    r_src_w    <= data_width_e'(i_data[1:0]);
                    REG_DST_W:    r_dst_w    <= data_width_e'(i_data[1:0]);
                    REG_TOTAL:    r_total    <= i_data;
                    default:      ;
                endcase
            end
        end
    end

    always_comb begin
        o_rd_word = '0;
        case (i_reg)
            REG_SRC:      o_rd_word = r_src;
            REG_DST:      o_rd_word = r_dst;
            REG_SRC_TYPE: o_rd_word = DATA_WIDTH'(r_src_type);
            REG_DST_TYPE: o_rd_word = DATA_WIDTH'(r_dst_type);
            REG_SRC_W:    o_rd_word = DATA_WIDTH'(r_src_w);
            REG_DST_W:    o_rd_word = DATA_WIDTH'(r_dst_w);
            REG_TOTAL:    o_rd_word = r_total;
            REG_CTRL:     o_rd_word = DATA_WIDTH'({r_hw_en, 1'b0});
            default:      o_rd_word = '0;
        endcase
    end

`ifdef DMA_RF_ERR_EN
    assign o_err = r_busy & ((i_wr_en & (i_reg != REG_CTRL)) | w_start_req);
`endif

    assign o_start     = r_start;
    assign o_busy      = r_busy;
    assign o_src_addr  = r_src;
    assign o_dst_addr  = r_dst;
    assign o_total     = r_total;
    assign o_src_type  = r_src_type;
    assign o_dst_type  = r_dst_type;
    assign o_src_width = r_src_w;
    assign o_dst_width = r_dst_w;

endmodule

// File: rtl/dma_ch_reg_file.sv
// DMA register file: per-channel config plus interrupt status/mask/busy.
// Optional error pulse output enabled by defining DMA_RF_ERR_EN.
module dma_ch_reg_file
    import dma_rf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic                         i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0]        i_addr,
    input  logic [DATA_WIDTH-1:0]        i_data,
    output logic                         o_ready,
    output logic [DATA_WIDTH-1:0]        o_rd_data,
    output logic                         o_rd_valid,
    input  logic [NUM_CH-1:0]            i_hw_trig,
    input  logic [NUM_CH-1:0]            i_ch_done,
    output logic [NUM_CH-1:0]            o_start,
    output logic [NUM_CH-1:0]            o_busy,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_src_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_dst_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_total,
    output logic [NUM_CH*2-1:0]          o_src_type,
    output logic [NUM_CH*2-1:0]          o_dst_type,
    output logic [NUM_CH*2-1:0]          o_src_width,
    output logic [NUM_CH*2-1:0]          o_dst_width,
    output logic                         o_irq,
    output logic                         o_err
);

    localparam logic [4:0] CH_LIMIT = 5'(NUM_CH);

    logic                  w_hi_zero;
    logic                  w_ch_hit;
    logic                  w_glb_hit;
    logic                  w_wr;
    logic                  w_rd;
    logic [4:0]            w_ch_idx;
    logic [2:0]            w_reg;
    logic                  w_status_wr;
    logic                  w_mask_wr;
    logic [NUM_CH-1:0]     w_ch_wr;
    logic [NUM_CH-1:0]     w_w1c;
    logic [DATA_WIDTH-1:0] w_ch_rd [NUM_CH];
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [NUM_CH-1:0]     r_status;
    logic [NUM_CH-1:0]     r_mask;
    logic                  r_irq;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    // Any address bit above bit 8 set means the access is unmapped.
    assign w_hi_zero = (i_addr >> 9) == '0;
    assign w_ch_idx  = i_addr[7:3];
    assign w_reg     = i_addr[2:0];
    assign w_ch_hit  = w_hi_zero & ~i_addr[8] & (w_ch_idx < CH_LIMIT);
    assign w_glb_hit = w_hi_zero
                     & (i_addr[8:2] == GLB_BASE[8:2])
                     & (i_addr[1:0] != 2'd3);

    assign w_wr = i_valid & i_rd0_wr1;
    assign w_rd = i_valid & ~i_rd0_wr1;

    assign w_status_wr = w_wr & w_glb_hit & (i_addr[1:0] == GLB_INT_STATUS);
    assign w_mask_wr   = w_wr & w_glb_hit & (i_addr[1:0] == GLB_INT_MASK);
    assign w_w1c       = w_status_wr ? i_data[NUM_CH-1:0] : '0;

`ifdef DMA_RF_ERR_EN
    logic [NUM_CH-1:0] w_ch_err;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_ch_wr[g] = w_wr & w_ch_hit & (w_ch_idx == 5'(g));

        dma_rf_channel #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_wr_en     (w_ch_wr[g]),
            .i_reg       (w_reg),
            .i_data      (i_data),
            .i_hw_trig   (i_hw_trig[g]),
            .i_ch_done   (i_ch_done[g]),
            .o_start     (o_start[g]),
            .o_busy      (o_busy[g]),
            .o_src_addr  (o_src_addr[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_dst_addr  (o_dst_addr[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_total     (o_total[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_src_type  (o_src_type[2*g +: 2]),
            .o_dst_type  (o_dst_type[2*g +: 2]),
            .o_src_width (o_src_width[2*g +: 2]),
            .o_dst_width (o_dst_width[2*g +: 2]),
            .o_rd_word   (w_ch_rd[g])
`ifdef DMA_RF_ERR_EN
            ,
            .o_err       (w_ch_err[g])
`endif
        );
    end

    always_comb begin
        w_rd_word = '0;
        if (w_ch_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_ch_idx == 5'(i))
                    w_rd_word = w_ch_rd[i];
            end
        end else if (w_glb_hit) begin
            case (i_addr[1:0])
                GLB_INT_STATUS: w_rd_word = DATA_WIDTH'(r_status);
                GLB_INT_MASK:   w_rd_word = DATA_WIDTH'(r_mask);
                GLB_BUSY:       w_rd_word = DATA_WIDTH'(o_busy);
                default:        w_rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status   <= '0;
            r_mask     <= '0;
            r_irq      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            // Done events win over a same-cycle write-1-to-clear.
            r_status   <= (r_status & ~w_w1c) | i_ch_done;
            if (w_mask_wr)
                r_mask <= i_data[NUM_CH-1:0];
            r_irq      <= |(r_status & r_mask);
            r_rd_valid <= w_rd;
            r_rd_data  <= w_rd ? w_rd_word : '0;
        end
    end

`ifdef DMA_RF_ERR_EN
    logic w_unmapped;
    logic r_err;

    assign w_unmapped = i_valid & ~(w_ch_hit | (w_glb_hit
                      & ~(i_rd0_wr1 & (i_addr[1:0] == GLB_BUSY))));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_err <= 1'b0;
        else
            r_err <= w_unmapped | (|w_ch_err);
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_ready    = 1'b1;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_irq      = r_irq;

endmodule

// File: tb/tb_dma_ch_reg_file.sv
// Directed bench for dma_ch_reg_file: bus table plus start/irq/reset sequences.
// Expected error pulses follow DMA_RF_ERR_EN when it is defined.
module tb_dma_ch_reg_file;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NC = 4;

`ifdef DMA_RF_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             i_rd0_wr1;
    logic [AW-1:0]    i_addr;
    logic [DW-1:0]    i_data;
    logic             o_ready;
    logic [DW-1:0]    o_rd_data;
    logic             o_rd_valid;
    logic [NC-1:0]    i_hw_trig;
    logic [NC-1:0]    i_ch_done;
    logic [NC-1:0]    o_start;
    logic [NC-1:0]    o_busy;
    logic [NC*DW-1:0] o_src_addr;
    logic [NC*DW-1:0] o_dst_addr;
    logic [NC*DW-1:0] o_total;
    logic [NC*2-1:0]  o_src_type;
    logic [NC*2-1:0]  o_dst_type;
    logic [NC*2-1:0]  o_src_width;
    logic [NC*2-1:0]  o_dst_width;
    logic             o_irq;
    logic             o_err;

    dma_ch_reg_file #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_rd0_wr1   (i_rd0_wr1),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_rd_data   (o_rd_data),
        .o_rd_valid  (o_rd_valid),
        .i_hw_trig   (i_hw_trig),
        .i_ch_done   (i_ch_done),
        .o_start     (o_start),
        .o_busy      (o_busy),
        .o_src_addr  (o_src_addr),
        .o_dst_addr  (o_dst_addr),
        .o_total     (o_total),
        .o_src_type  (o_src_type),
        .o_dst_type  (o_dst_type),
        .o_src_width (o_src_width),
        .o_dst_width (o_dst_width),
        .o_irq       (o_irq),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int start_cnt [NC];

    initial begin
        for (int i = 0; i < NC; i++) start_cnt[i] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++)
            if (o_start[i] === 1'b1) start_cnt[i] = start_cnt[i] + 1;
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one bus cycle from a negedge; returns at the following negedge.
    task automatic bus_op(input logic wr, input logic [31:0] a,
                          input logic [31:0] d);
        i_valid   = 1'b1;
        i_rd0_wr1 = wr;
        i_addr    = a;
        i_data    = d;
        @(negedge clk);
        i_valid   = 1'b0;
        i_rd0_wr1 = 1'b0;
        i_data    = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp,
                            input string nm);
        bus_op(1'b0, a, '0);
        chk({nm, "_vld"}, 64'(o_rd_valid), 64'd1);
        chk(nm, 64'(o_rd_data), 64'(exp));
    endtask

    task automatic pulse_done(input int ch);
        i_ch_done[ch] = 1'b1;
        @(negedge clk);
        i_ch_done = '0;
    endtask

    task automatic pulse_trig(input int ch);
        i_hw_trig[ch] = 1'b1;
        @(negedge clk);
        i_hw_trig = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int base0;
    int base2;
    int snap [NC];

    initial begin
        vecs[0]  = '{1'b1, 32'h008, 32'h1000_0000, 32'h0,         "w_ch1_src"};
        vecs[1]  = '{1'b0, 32'h008, 32'h0,         32'h1000_0000, "r_ch1_src"};
        vecs[2]  = '{1'b1, 32'h00A, 32'hFF,        32'h0,         "w_ch1_stype"};
        vecs[3]  = '{1'b0, 32'h00A, 32'h0,         32'h3,         "r_ch1_stype"};
        vecs[4]  = '{1'b1, 32'h014, 32'h6,         32'h0,         "w_ch2_srcw"};
        vecs[5]  = '{1'b0, 32'h014, 32'h0,         32'h2,         "r_ch2_srcw"};
        vecs[6]  = '{1'b1, 32'h00E, 32'h1234,      32'h0,         "w_ch1_total"};
        vecs[7]  = '{1'b0, 32'h00E, 32'h0,         32'h1234,      "r_ch1_total"};
        vecs[8]  = '{1'b0, 32'h020, 32'h0,         32'h0,         "r_ch4_unmap"};
        vecs[9]  = '{1'b1, 32'h020, 32'hDEAD,      32'h0,         "w_ch4_unmap"};
        vecs[10] = '{1'b0, 32'h020, 32'h0,         32'h0,         "r_ch4_again"};
        vecs[11] = '{1'b1, 32'h101, 32'hFF,        32'h0,         "w_mask"};
        vecs[12] = '{1'b0, 32'h101, 32'h0,         32'hF,         "r_mask"};
        vecs[13] = '{1'b0, 32'h103, 32'h0,         32'h0,         "r_glb_unmap"};
        vecs[14] = '{1'b1, 32'h00F, 32'h2,         32'h0,         "w_ch1_hwen"};
        vecs[15] = '{1'b0, 32'h00F, 32'h0,         32'h2,         "r_ch1_ctrl"};
        vecs[16] = '{1'b0, 32'h102, 32'h0,         32'h0,         "r_busy_idle"};
        vecs[17] = '{1'b1, 32'h200, 32'hAAAA,      32'h0,         "w_hi_unmap"};
        vecs[18] = '{1'b0, 32'h000, 32'h0,         32'h0,         "r_ch0_src"};
        vecs[19] = '{1'b0, 32'h009, 32'h0,         32'h0,         "r_ch1_dst"};

        rst       = 1'b0;
        i_valid   = 1'b0;
        i_rd0_wr1 = 1'b0;
        i_addr    = '0;
        i_data    = '0;
        i_hw_trig = '0;
        i_ch_done = '0;
        idle(2);

        chk("rst_ready",  64'(o_ready),    64'd1);
        chk("rst_busy",   64'(o_busy),     64'd0);
        chk("rst_start",  64'(o_start),    64'd0);
        chk("rst_rdvld",  64'(o_rd_valid), 64'd0);
        chk("rst_irq",    64'(o_irq),      64'd0);
        chk("rst_err",    64'(o_err),      64'd0);
        rst = 1'b1;
        idle(1);

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wr) begin
                bus_op(1'b1, vecs[i].addr, vecs[i].data);
                chk({vecs[i].name, "_novld"}, 64'(o_rd_valid), 64'd0);
            end else begin
                bus_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
            end
        end
        chk("cfg_src1",   64'(o_src_addr[63:32]), 64'h1000_0000);
        chk("cfg_stype1", 64'(o_src_type[3:2]),   64'd3);
        chk("cfg_srcw2",  64'(o_src_width[5:4]),  64'd2);

        // Software start on ch0, then a config write while busy.
        base0 = start_cnt[0];
        bus_op(1'b1, 32'h006, 32'h10);
        bus_op(1'b1, 32'h007, 32'h1);
        chk("sw_start0", 64'(o_start[0]), 64'd1);
        chk("sw_busy0",  64'(o_busy[0]),  64'd1);
        bus_op(1'b1, 32'h006, 32'h55);
        chk("sw_start0_off", 64'(o_start[0]), 64'd0);
        chk("busy_wr_err",   64'(o_err),      64'(EXP_ERR));
        chk("busy_total0",   64'(o_total[31:0]), 64'h10);
        bus_read(32'h007, 32'h0, "r_ctrl0_selfclr");
        bus_read(32'h102, 32'h1, "r_busy_ch0");
        chk("sw_cnt0", 64'(start_cnt[0] - base0), 64'd1);

        pulse_done(0);
        chk("done_busy0", 64'(o_busy[0]), 64'd0);
        bus_read(32'h100, 32'h1, "r_stat_ch0");
        chk("irq_ch0", 64'(o_irq), 64'd1);
        bus_op(1'b1, 32'h100, 32'h1);
        bus_read(32'h100, 32'h0, "r_stat_w1c0");
        chk("irq_ch0_clr", 64'(o_irq), 64'd0);

        // Hardware trigger on ch2, retrigger while busy is ignored.
        base2 = start_cnt[2];
        bus_op(1'b1, 32'h017, 32'h2);
        pulse_trig(2);
        chk("hw_start2", 64'(o_start[2]), 64'd1);
        chk("hw_busy2",  64'(o_busy[2]),  64'd1);
        idle(2);
        pulse_trig(2);
        chk("hw_retrig_start", 64'(o_start[2]), 64'd0);
        chk("hw_retrig_err",   64'(o_err),      64'(EXP_ERR));
        idle(3);
        chk("hw_cnt2", 64'(start_cnt[2] - base2), 64'd1);

        // Masked interrupt from ch2.
        bus_op(1'b1, 32'h101, 32'h4);
        pulse_done(2);
        chk("done_busy2", 64'(o_busy[2]), 64'd0);
        chk("irq_lat0",   64'(o_irq),     64'd0);
        idle(1);
        chk("irq_ch2",    64'(o_irq),     64'd1);
        bus_read(32'h100, 32'h4, "r_stat_ch2");
        bus_op(1'b1, 32'h100, 32'h4);
        idle(1);
        chk("irq_ch2_clr", 64'(o_irq), 64'd0);

        // Done and W1C of the same bit in one cycle: set wins.
        pulse_done(1);
        i_ch_done = 4'b0010;
        bus_op(1'b1, 32'h100, 32'h2);
        i_ch_done = '0;
        bus_read(32'h100, 32'h2, "r_stat_race");
        chk("irq_masked1", 64'(o_irq), 64'd0);
        bus_op(1'b1, 32'h100, 32'h2);
        bus_read(32'h100, 32'h0, "r_stat_w1c1");

        // CTRL write to a busy channel updates HW_EN only.
        base0 = start_cnt[0];
        bus_op(1'b1, 32'h007, 32'h1);
        bus_op(1'b1, 32'h007, 32'h3);
        chk("busy_ctrl_err", 64'(o_err), 64'(EXP_ERR));
        bus_read(32'h007, 32'h2, "r_ctrl0_hwen");
        chk("busy_ctrl_cnt", 64'(start_cnt[0] - base0), 64'd1);
        chk("busy_ch0_pre",  64'(o_busy[0]), 64'd1);

        // Reset while ch0 is busy.
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(o_busy),     64'd0);
        chk("mid_rst_start", 64'(o_start),    64'd0);
        chk("mid_rst_rdvld", 64'(o_rd_valid), 64'd0);
        chk("mid_rst_rdata", 64'(o_rd_data),  64'd0);
        chk("mid_rst_irq",   64'(o_irq),      64'd0);
        chk("mid_rst_err",   64'(o_err),      64'd0);
        chk("mid_rst_ready", 64'(o_ready),    64'd1);
        chk("mid_rst_src",   64'(o_src_addr[63:32]), 64'd0);
        chk("mid_rst_tot",   64'(o_total[31:0]),     64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NC; i++) snap[i] = start_cnt[i];
        idle(4);
        chk("post_rst_cnt0", 64'(start_cnt[0] - snap[0]), 64'd0);
        chk("post_rst_cnt2", 64'(start_cnt[2] - snap[2]), 64'd0);
        chk("post_rst_busy", 64'(o_busy), 64'd0);
        bus_read(32'h100, 32'h0, "r_stat_rst");
        bus_read(32'h101, 32'h0, "r_mask_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
